vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with registered levels and strobe-gated pulses.
// Define VGA_TIMING_FRAME_CNT_EN to build the o_frame counter; otherwise o_frame is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 12,
  parameter int FW       = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_pix_stb,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_active,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic          o_linestart,
  output logic          o_screenend,
  output logic          o_animate,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic [FW-1:0] o_frame
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS = H_ACTIVE + H_FP;
  localparam int H_SE = H_SS + H_SYNC;
  localparam int V_SS = V_ACTIVE + V_FP;
  localparam int V_SE = V_SS + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_MAX  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX  = CW'(V_ACTIVE - 1);

  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic hs_q, hs_d, vs_q, vs_d, hblank_q, hblank_d, vblank_q, vblank_d, active_q;
  logic h_wrap, v_wrap;

  // Levels are decoded from the next position so they describe the pixel now held.
  always_comb begin
    h_wrap   = h_q == H_LAST;
    v_wrap   = v_q == V_LAST;
    h_d      = !i_pix_stb ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d      = !(i_pix_stb && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
    hblank_d = int'(h_d) >= H_ACTIVE;
    vblank_d = int'(v_d) >= V_ACTIVE;
    hs_d     = (int'(h_d) >= H_SS && int'(h_d) < H_SE) ? H_POL : !H_POL;
    vs_d     = (int'(v_d) >= V_SS && int'(v_d) < V_SE) ? V_POL : !V_POL;
    x_d      = hblank_d ? X_MAX : h_d;
    y_d      = vblank_d ? Y_MAX : v_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q      <= '0;
      v_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= !H_POL;
      vs_q     <= !V_POL;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      active_q <= 1'b1;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      active_q <= !hblank_d && !vblank_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FW-1:0] frame_q, frame_d;
  always_comb frame_d = (i_pix_stb && h_wrap && v_wrap) ? frame_q + 1'b1 : frame_q;
  always_ff @(posedge i_clk) frame_q <= i_rst ? '0 : frame_d;
  assign o_frame = frame_q;
`else
  assign o_frame = {FW{1'b0}};
`endif

  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_active    = active_q;
  assign o_hblank    = hblank_q;
  assign o_vblank    = vblank_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_linestart = i_pix_stb && !i_rst && h_wrap;
  assign o_animate   = i_pix_stb && !i_rst && h_wrap && v_q == Y_MAX;
  assign o_screenend = i_pix_stb && !i_rst && h_wrap && v_wrap;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default, a 640x480 and a tiny 15x8 instance sharing clk/rst/stb.
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FEN = 1;
`else
  localparam int FEN = 0;
`endif

  logic hs0, vs0, ac0, hb0, vb0, ls0, se0, an0;
  logic [11:0] x0, y0;
  logic [15:0] fr0;
  logic hs1, vs1, ac1, hb1, vb1, ls1, se1, an1;
  logic [11:0] x1, y1;
  logic [15:0] fr1;
  logic hs2, vs2, ac2, hb2, vb2, ls2, se2, an2;
  logic [4:0] x2, y2;
  logic [3:0] fr2;

  vga_timing_gen u0 (.i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .o_hs(hs0), .o_vs(vs0),
    .o_active(ac0), .o_hblank(hb0), .o_vblank(vb0), .o_linestart(ls0), .o_screenend(se0),
    .o_animate(an0), .o_x(x0), .o_y(y0), .o_frame(fr0));
  vga_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48), .V_ACTIVE(480), .V_FP(10),
    .V_SYNC(2), .V_BP(33), .H_POL(1'b1), .V_POL(1'b1)) u1 (.i_clk(clk), .i_rst(rst),
    .i_pix_stb(stb), .o_hs(hs1), .o_vs(vs1), .o_active(ac1), .o_hblank(hb1), .o_vblank(vb1),
    .o_linestart(ls1), .o_screenend(se1), .o_animate(an1), .o_x(x1), .o_y(y1), .o_frame(fr1));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .CW(5), .FW(4)) u2 (.i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_hs(hs2), .o_vs(vs2), .o_active(ac2), .o_hblank(hb2), .o_vblank(vb2), .o_linestart(ls2),
    .o_screenend(se2), .o_animate(an2), .o_x(x2), .o_y(y2), .o_frame(fr2));

  task automatic reset_cycle();
    rst = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stb = 1'b1; #1;
    total++; if (se2 !== 1'b0 || ls2 !== 1'b0) begin bad++; $display("FAIL rst_pulse got ls=%b se=%b want 0", ls2, se2); end
    @(posedge clk); #1;
    total++; if (x0 !== 12'd0 || y0 !== 12'd0) begin bad++; $display("FAIL rst_xy got %0d,%0d want 0,0", x0, y0); end
    total++; if ({ac0, hb0, vb0} !== 3'b100) begin bad++; $display("FAIL rst_blank got act/hb/vb=%b%b%b want 100", ac0, hb0, vb0); end
    total++; if ({hs0, vs0} !== 2'b11) begin bad++; $display("FAIL rst_sync0 got %b%b want 11", hs0, vs0); end
    total++; if ({hs1, vs1} !== 2'b00) begin bad++; $display("FAIL rst_sync1 got %b%b want 00", hs1, vs1); end
    total++; if (fr0 !== 16'd0) begin bad++; $display("FAIL rst_frame got %0d want 0", fr0); end
    rst = 1'b0;
  endtask

  task automatic test_hline();
    int s = 0, nlow0 = 0, first0 = -1, nhi1 = 0, first1 = -1, nls0 = 0, pls0 = -1, nls1 = 0, pls1 = -1;
    for (int c = 0; c < 1344; c++) begin
      rst = 1'b0; stb = 1'b1; #1;
      if (ls0) begin nls0++; pls0 = s; end
      if (ls1) begin nls1++; pls1 = s; end
      @(posedge clk); #1;
      s++;
      if (hs0 === 1'b0) begin if (first0 < 0) first0 = s; nlow0++; end
      if (hs1 === 1'b1) begin if (first1 < 0) first1 = s; nhi1++; end
      if (s == 700) begin
        total++; if (x1 !== 12'd639 || hb1 !== 1'b1) begin bad++; $display("FAIL x_clamp640 got x=%0d hb=%b want 639,1", x1, hb1); end
      end
      if (s == 800) begin
        total++; if (x1 !== 12'd0 || y1 !== 12'd1) begin bad++; $display("FAIL wrap800 got %0d,%0d want 0,1", x1, y1); end
      end
      if (s == 1023) begin
        total++; if (x0 !== 12'd1023 || ac0 !== 1'b1) begin bad++; $display("FAIL last_active got x=%0d act=%b want 1023,1", x0, ac0); end
      end
      if (s == 1024) begin
        total++; if (x0 !== 12'd1023 || ac0 !== 1'b0 || hb0 !== 1'b1) begin bad++; $display("FAIL first_blank got x=%0d act=%b hb=%b want 1023,0,1", x0, ac0, hb0); end
      end
    end
    total++; if (nlow0 != 136 || first0 != 1048) begin bad++; $display("FAIL hsync_default got n=%0d first=%0d want 136,1048", nlow0, first0); end
    total++; if (nhi1 != 96 || first1 != 656) begin bad++; $display("FAIL hsync_640 got n=%0d first=%0d want 96,656", nhi1, first1); end
    total++; if (nls0 != 1 || pls0 != 1343) begin bad++; $display("FAIL linestart_default got n=%0d at=%0d want 1,1343", nls0, pls0); end
    total++; if (nls1 != 1 || pls1 != 799) begin bad++; $display("FAIL linestart_640 got n=%0d at=%0d want 1,799", nls1, pls1); end
    total++; if (x0 !== 12'd0 || y0 !== 12'd1 || ac0 !== 1'b1 || vs0 !== 1'b1) begin bad++; $display("FAIL line1_default got x=%0d y=%0d act=%b vs=%b want 0,1,1,1", x0, y0, ac0, vs0); end
  endtask

  task automatic test_frame();
    int s = 0, nan = 0, pan = -1, nse = 0, pse = -1, nls = 0, nvs = 0, fvs = -1;
    reset_cycle();
    for (int c = 0; c < 120; c++) begin
      stb = 1'b1; #1;
      if (an2) begin nan++; pan = s; end
      if (se2) begin nse++; pse = s; end
      if (ls2) nls++;
      @(posedge clk); #1;
      s++;
      if (vs2 === 1'b0) begin if (fvs < 0) fvs = s; nvs++; end
      if (s == 10) begin
        total++; if (x2 !== 5'd7 || hb2 !== 1'b1 || hs2 !== 1'b0) begin bad++; $display("FAIL x_clamp_small got x=%0d hb=%b hs=%b want 7,1,0", x2, hb2, hs2); end
      end
      if (s == 100) begin
        total++; if (y2 !== 5'd3 || vb2 !== 1'b1 || ac2 !== 1'b0) begin bad++; $display("FAIL y_clamp got y=%0d vb=%b act=%b want 3,1,0", y2, vb2, ac2); end
      end
      if (s == 119) begin
        total++; if (int'(fr2) != 0) begin bad++; $display("FAIL frame_early got %0d want 0", fr2); end
      end
    end
    total++; if (nan != 1 || pan != 59) begin bad++; $display("FAIL animate got n=%0d at=%0d want 1,59", nan, pan); end
    total++; if (nse != 1 || pse != 119) begin bad++; $display("FAIL screenend got n=%0d at=%0d want 1,119", nse, pse); end
    total++; if (nls != 8) begin bad++; $display("FAIL linestarts got %0d want 8", nls); end
    total++; if (nvs != 30 || fvs != 75) begin bad++; $display("FAIL vsync got n=%0d first=%0d want 30,75", nvs, fvs); end
    total++; if (x2 !== 5'd0 || y2 !== 5'd0 || ac2 !== 1'b1) begin bad++; $display("FAIL next_frame got %0d,%0d act=%b want 0,0,1", x2, y2, ac2); end
    total++; if (int'(fr2) != FEN) begin bad++; $display("FAIL frame_count got %0d want %0d", fr2, FEN); end
  endtask

  task automatic test_slow_strobe();
    int s = 0, nls = 0, px;
    logic pls = 1'b0;
    reset_cycle();
    px = int'(x2);
    for (int c = 0; c < 240; c++) begin
      stb = (c % 4 == 0); #1;
      if ((ls2 || an2 || se2) && !stb) begin total++; bad++; $display("FAIL pulse_nostb at c=%0d", c); end
      if (ls2 && pls) begin total++; bad++; $display("FAIL pulse_width at c=%0d", c); end
      if (ls2) nls++;
      pls = ls2;
      @(posedge clk); #1;
      if (stb) s++;
      total++;
      if (int'(x2) != ((s % 15) < 8 ? s % 15 : 7)) begin bad++; $display("FAIL slow_x c=%0d got %0d want %0d", c, x2, (s % 15) < 8 ? s % 15 : 7); end
      if (!stb && int'(x2) != px) begin total++; bad++; $display("FAIL hold c=%0d got %0d want %0d", c, x2, px); end
      px = int'(x2);
    end
    total++; if (nls != 4) begin bad++; $display("FAIL slow_linestarts got %0d want 4", nls); end
  endtask

  task automatic test_reset_mid();
    reset_cycle();
    for (int c = 0; c < 119; c++) begin stb = 1'b1; @(posedge clk); #1; end
    total++; if (x2 !== 5'd7 || y2 !== 5'd3 || vb2 !== 1'b1) begin bad++; $display("FAIL pre_rst_pos got %0d,%0d vb=%b want 7,3,1", x2, y2, vb2); end
    rst = 1'b1; stb = 1'b1; #1;
    total++; if (se2 !== 1'b0) begin bad++; $display("FAIL rst_screenend got %b want 0", se2); end
    @(posedge clk); #1;
    total++; if (x2 !== 5'd0 || y2 !== 5'd0 || ac2 !== 1'b1 || vs2 !== 1'b1) begin bad++; $display("FAIL rst_mid got %0d,%0d act=%b vs=%b want 0,0,1,1", x2, y2, ac2, vs2); end
    total++; if (fr2 !== 4'd0 || x0 !== 12'd0) begin bad++; $display("FAIL rst_mid_frame got fr=%0d x0=%0d want 0,0", fr2, x0); end
    rst = 1'b0; @(posedge clk); #1;
    total++; if (x2 !== 5'd1 || x0 !== 12'd1) begin bad++; $display("FAIL after_rst got %0d/%0d want 1/1", x2, x0); end
  endtask

  task automatic test_three_frames();
    int nse = 0;
    reset_cycle();
    for (int c = 0; c < 360; c++) begin
      stb = 1'b1; #1;
      if (se2) nse++;
      @(posedge clk); #1;
    end
    total++; if (nse != 3) begin bad++; $display("FAIL screenend_3 got %0d want 3", nse); end
    total++; if (int'(fr2) != 3 * FEN) begin bad++; $display("FAIL frame_3 got %0d want %0d", fr2, 3 * FEN); end
    total++; if (x2 !== 5'd0 || y2 !== 5'd0) begin bad++; $display("FAIL end_3 got %0d,%0d want 0,0", x2, y2); end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_frame();
    test_slow_strobe();
    test_reset_mid();
    test_three_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
